// File: rtl/chronologic.sv
// chronologic: registered checker for "c high at edge k implies a == b at edge k+1".
// Optional CHRONOLOGIC_FAIL_CAPTURE_EN adds first-failure capture of a, b and a cycle stamp.
module chronologic #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             pending,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
    ,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_a,
    output logic [WIDTH-1:0] cap_b,
    output logic [31:0]      cap_cycle
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             pending_q, pending_d;
    logic             pass_pulse_q, pass_pulse_d;
    logic             fail_pulse_q, fail_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             pass_now, fail_now;

`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
    logic             cap_valid_q, cap_valid_d;
    logic [WIDTH-1:0] cap_a_q, cap_a_d;
    logic [WIDTH-1:0] cap_b_q, cap_b_d;
    logic [31:0]      cap_cycle_q, cap_cycle_d;
    logic [31:0]      cycle_q, cycle_d;
`endif

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        pass_now     = pending_q & (a == b);
        fail_now     = pending_q & (a != b);
        pending_d    = c & en;
        pass_pulse_d = pass_now;
        fail_pulse_d = fail_now;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        err_sticky_d = err_sticky_q | fail_now;

        // clr discards a result finishing on the same edge, but not the pulses.
        if (clr) begin
            pass_cnt_d   = '0;
            fail_cnt_d   = '0;
            err_sticky_d = 1'b0;
        end else begin
            if (pass_now && pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
            if (fail_now && fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
        end

`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
        cycle_d     = cycle_q + 32'd1;
        cap_valid_d = cap_valid_q;
        cap_a_d     = cap_a_q;
        cap_b_d     = cap_b_q;
        cap_cycle_d = cap_cycle_q;
        if (clr) begin
            cap_valid_d = 1'b0;
        end else if (fail_now && !cap_valid_q) begin
            cap_valid_d = 1'b1;
            cap_a_d     = a;
            cap_b_d     = b;
            cap_cycle_d = cycle_q;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= 1'b0;
            pass_pulse_q <= 1'b0;
            fail_pulse_q <= 1'b0;
            err_sticky_q <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
            cap_valid_q  <= 1'b0;
            cap_a_q      <= '0;
            cap_b_q      <= '0;
            cap_cycle_q  <= '0;
            cycle_q      <= '0;
`endif
        end else begin
            pending_q    <= pending_d;
            pass_pulse_q <= pass_pulse_d;
            fail_pulse_q <= fail_pulse_d;
            err_sticky_q <= err_sticky_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
            cap_valid_q  <= cap_valid_d;
            cap_a_q      <= cap_a_d;
            cap_b_q      <= cap_b_d;
            cap_cycle_q  <= cap_cycle_d;
            cycle_q      <= cycle_d;
`endif
        end
    end

    assign pending    = pending_q;
    assign pass_pulse = pass_pulse_q;
    assign fail_pulse = fail_pulse_q;
    assign err_sticky = err_sticky_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;
`ifdef CHRONOLOGIC_FAIL_CAPTURE_EN
    assign cap_valid  = cap_valid_q;
    assign cap_a      = cap_a_q;
    assign cap_b      = cap_b_q;
    assign cap_cycle  = cap_cycle_q;
`endif

endmodule

// File: tb/tb_chronologic.sv
// Self-checking bench for chronologic: directed vector table, counter saturation sequence,
// and randomized traffic against a queue-based reference model.
module tb_chronologic;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, en, clr, c;
    logic [W-1:0] a, b;

    logic         pending, pass_pulse, fail_pulse, err_sticky;
    logic [15:0]  pass_cnt, fail_cnt;
    logic         s_pending, s_pass_pulse, s_fail_pulse, s_err_sticky;
    logic [1:0]   s_pass_cnt, s_fail_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    chronologic #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c),
        .pending(pending), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .err_sticky(err_sticky), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    chronologic #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c),
        .pending(s_pending), .pass_pulse(s_pass_pulse), .fail_pulse(s_fail_pulse),
        .err_sticky(s_err_sticky), .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
    );

    // Reference model: a queue of edge numbers at which a check is due.
    int unsigned due_q[$];
    int unsigned edge_no = 0;
    bit          m_pass, m_fail, m_err, m_pend;
    int          m_pc, m_fc, m_pc2, m_fc2;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s (edge %0d): got %0h expected %0h", name, edge_no, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit cl, input bit cc,
                              input logic [W-1:0] aa, input logic [W-1:0] bb);
        bit due;
        edge_no++;
        m_pass = 0;
        m_fail = 0;
        if (r) begin
            due_q.delete();
            m_err = 0;
            m_pc = 0; m_fc = 0; m_pc2 = 0; m_fc2 = 0;
        end else begin
            due = (due_q.size() > 0) && (due_q[0] == edge_no);
            if (due) void'(due_q.pop_front());
            m_pass = due && (aa == bb);
            m_fail = due && (aa != bb);
            if (cl) begin
                m_err = 0;
                m_pc = 0; m_fc = 0; m_pc2 = 0; m_fc2 = 0;
            end else begin
                m_err = m_err | m_fail;
                if (m_pass) begin
                    m_pc  = (m_pc  < 65535) ? m_pc  + 1 : m_pc;
                    m_pc2 = (m_pc2 < 3)     ? m_pc2 + 1 : m_pc2;
                end
                if (m_fail) begin
                    m_fc  = (m_fc  < 65535) ? m_fc  + 1 : m_fc;
                    m_fc2 = (m_fc2 < 3)     ? m_fc2 + 1 : m_fc2;
                end
            end
            if (cc && e) due_q.push_back(edge_no + 1);
        end
        m_pend = (due_q.size() > 0);
    endtask

    // Apply inputs for one edge, advance the model, compare both DUTs against it.
    task automatic step(input bit r, input bit e, input bit cl, input bit cc,
                        input logic [W-1:0] aa, input logic [W-1:0] bb);
        rst = r; en = e; clr = cl; c = cc; a = aa; b = bb;
        @(posedge clk);
        #1;
        model_edge(r, e, cl, cc, aa, bb);
        check("model_pending",   32'(pending),    32'(m_pend));
        check("model_pass",      32'(pass_pulse), 32'(m_pass));
        check("model_fail",      32'(fail_pulse), 32'(m_fail));
        check("model_err",       32'(err_sticky), 32'(m_err));
        check("model_pass_cnt",  32'(pass_cnt),   32'(m_pc));
        check("model_fail_cnt",  32'(fail_cnt),   32'(m_fc));
        check("sat_pass_cnt",    32'(s_pass_cnt), 32'(m_pc2));
        check("sat_fail_cnt",    32'(s_fail_cnt), 32'(m_fc2));
    endtask

    typedef struct {
        bit           rst, en, clr, c;
        logic [W-1:0] a, b;
        bit           pend, pass, fail, err;
        int           pc, fc;
    } vec_t;

    vec_t vecs[21];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst en clr c  a  b   pend pass fail err pc fc
        vecs[0]  = '{1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 1, 0, 5,   1, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 3, 3,   0, 1, 0, 0, 1, 0};
        vecs[3]  = '{0, 1, 0, 1, 0, 0,   1, 0, 0, 0, 1, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 1,   0, 0, 1, 1, 1, 1};
        vecs[5]  = '{0, 1, 0, 0, 2, 7,   0, 0, 0, 1, 1, 1};
        vecs[6]  = '{0, 1, 0, 1, 9, 9,   1, 0, 0, 1, 1, 1};
        vecs[7]  = '{0, 1, 0, 1, 4, 4,   1, 1, 0, 1, 2, 1};
        vecs[8]  = '{0, 1, 0, 1, 1, 2,   1, 0, 1, 1, 2, 2};
        vecs[9]  = '{0, 1, 0, 0, 1, 3,   0, 0, 1, 1, 2, 3};
        vecs[10] = '{0, 1, 1, 0, 5, 6,   0, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 1, 5, 6,   0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 1, 0, 0, 1, 2,   0, 0, 0, 0, 0, 0};
        vecs[13] = '{0, 1, 0, 1, 1, 2,   1, 0, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 1, 6, 6,   0, 1, 0, 0, 1, 0};
        vecs[15] = '{0, 1, 0, 1, 6, 7,   1, 0, 0, 0, 1, 0};
        vecs[16] = '{1, 1, 0, 0, 1, 2,   0, 0, 0, 0, 0, 0};
        vecs[17] = '{0, 1, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0};
        vecs[18] = '{0, 1, 1, 1, 1, 2,   1, 0, 1, 0, 0, 0};
        vecs[19] = '{0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0};
        vecs[20] = '{1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};

        rst = 1; en = 0; clr = 0; c = 0; a = '0; b = '0;
        m_err = 0; m_pc = 0; m_fc = 0; m_pc2 = 0; m_fc2 = 0;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].c, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_pending", i),  32'(pending),    32'(vecs[i].pend));
            check($sformatf("vec%0d_pass", i),     32'(pass_pulse), 32'(vecs[i].pass));
            check($sformatf("vec%0d_fail", i),     32'(fail_pulse), 32'(vecs[i].fail));
            check($sformatf("vec%0d_err", i),      32'(err_sticky), 32'(vecs[i].err));
            check($sformatf("vec%0d_pass_cnt", i), 32'(pass_cnt),   32'(vecs[i].pc));
            check($sformatf("vec%0d_fail_cnt", i), 32'(fail_cnt),   32'(vecs[i].fc));
        end

        // Saturation: five passing checks back to back, then clr.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 4'(i), 4'(i));
        step(0, 1, 0, 0, 4'd7, 4'd7);
        check("sat_seq_pass_cnt_w2",  32'(s_pass_cnt), 32'd3);
        check("sat_seq_pass_cnt_w16", 32'(pass_cnt),   32'd5);
        step(0, 1, 1, 0, 4'd0, 4'd0);
        check("sat_seq_clr_w2",  32'(s_pass_cnt), 32'd0);
        check("sat_seq_clr_w16", 32'(pass_cnt),   32'd0);

        // Randomized traffic, checked against the model inside step().
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(1, 0) == 1) ? ra : W'($urandom);
            step($urandom_range(39, 0) == 0, $urandom_range(3, 0) != 0,
                 $urandom_range(15, 0) == 0, $urandom_range(1, 0) == 1, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
